apb_master_multi: RTL and testbench

- Parametrised successor to the single-channel APB master.
- Takes one request at a time on the internal transfer/ready interface and decodes the address onto NUM_SLV slave regions.
- Runs the APB SETUP/ACCESS protocol, returns read data and an error flag (PSLVERR, decode miss, optional timeout).
- Supports back-to-back transfers with no idle cycle between them.
- Sits between the CPU-side bus glue and the APB peripherals (RAM slave, register slaves).

---
 rtl/apb_master_multi_pkg.sv | 19 +
 rtl/apb_master_multi_if.sv | 35 +++
 rtl/apb_master_multi_addr_decoder.sv | 27 ++
 rtl/apb_master_multi.sv | 119 +++++++++++
 tb/tb_apb_master_multi.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_multi_pkg.sv
// rtl/apb_master_multi_pkg.sv - FSM states, select-width helper and default window for the multi-slave APB master
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR
  } apb_state_e;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1000_0000;
  localparam int          DEF_REGION_BITS = 12;

  // Never narrower than one bit, so a single-slave build still has a legal index vector.
  function automatic int sel_w(input int num_slv);
    return (num_slv > 1) ? $clog2(num_slv) : 1;
  endfunction

endpackage

// File: rtl/apb_master_multi_if.sv
// rtl/apb_master_multi_if.sv - request/response handshake plus APB bus bundle for apb_master_multi
interface apb_master_multi_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);

  logic                      transfer;
  logic                      write;
  logic [ADDR_W-1:0]         addr;
  logic [DATA_W-1:0]         wdata;
  logic                      ready;
  logic [DATA_W-1:0]         rdata;
  logic                      err;

  logic [ADDR_W-1:0]         PADDR;
  logic                      PWRITE;
  logic                      PENABLE;
  logic [DATA_W-1:0]         PWDATA;
  logic [NUM_SLV-1:0]        PSEL;
  logic [NUM_SLV*DATA_W-1:0] PRDATA;
  logic [NUM_SLV-1:0]        PREADY;
  logic [NUM_SLV-1:0]        PSLVERR;

  modport master (
    input  transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
    output ready, rdata, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

  modport slave (
    output transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
    input  ready, rdata, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

endinterface

// File: rtl/apb_master_multi_addr_decoder.sv
// rtl/apb_master_multi_addr_decoder.sv - maps a request address onto a slave index inside the APB window
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int                REGION_BITS = DEF_REGION_BITS,
  localparam int               SEL_W       = sel_w(NUM_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [SEL_W-1:0]  idx
);

  localparam int TOP_LSB = REGION_BITS + SEL_W;

  logic top_match;
  logic idx_ok;

  assign idx       = addr[REGION_BITS +: SEL_W];
  assign top_match = (addr[ADDR_W-1:TOP_LSB] == BASE_ADDR[ADDR_W-1:TOP_LSB]);
  // Non-power-of-two slave counts leave unused indices inside the window.
  assign idx_ok    = ({{(32-SEL_W){1'b0}}, idx} < 32'(NUM_SLV));
  assign hit       = top_match && idx_ok;

endmodule

// File: rtl/apb_master_multi.sv
// rtl/apb_master_multi.sv - APB master decoding one request at a time onto NUM_SLV slave selects
// Optional ACCESS timeout is compiled in with APB_TIMEOUT_EN.
module apb_master_multi
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
`ifdef APB_TIMEOUT_EN
  parameter int                TIMEOUT_CYC = 16,
`endif
  parameter int                REGION_BITS = DEF_REGION_BITS
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_master_multi_if.master bus
);

  localparam int SEL_W = sel_w(NUM_SLV);

  apb_state_e        state;
  logic [SEL_W-1:0]  lat_idx;
  logic [SEL_W-1:0]  dec_idx;
  logic              dec_hit;
  logic              pready_sel;
  logic              pslverr_sel;
  logic [DATA_W-1:0] prdata_sel;
  logic              done_ok;
  logic              timeout;
  logic              complete;
  logic              take;

  apb_addr_decoder #(
    .ADDR_W      (ADDR_W),
    .NUM_SLV     (NUM_SLV),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS)
  ) u_dec (
    .addr (bus.addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign pready_sel  = bus.PREADY[lat_idx];
  assign pslverr_sel = bus.PSLVERR[lat_idx];
  assign prdata_sel  = bus.PRDATA[lat_idx*DATA_W +: DATA_W];

  assign done_ok  = (state == ACCESS) && pready_sel;
  assign complete = done_ok || timeout;
  // A new request is accepted only from IDLE or in the cycle the current one completes.
  assign take     = bus.transfer && ((state == IDLE) || complete);

  assign bus.ready = complete || (state == DECERR);
  assign bus.err   = (done_ok && pslverr_sel) || timeout || (state == DECERR);
  assign bus.rdata = (done_ok && !bus.PWRITE) ? prdata_sel : '0;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout = (state == ACCESS) && !pready_sel && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready_sel) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      lat_idx     <= '0;
      bus.PADDR   <= '0;
      bus.PWRITE  <= 1'b0;
      bus.PWDATA  <= '0;
      bus.PSEL    <= '0;
      bus.PENABLE <= 1'b0;
    end else if (take) begin
      bus.PENABLE <= 1'b0;
      if (dec_hit) begin
        state      <= SETUP;
        lat_idx    <= dec_idx;
        bus.PADDR  <= bus.addr;
        bus.PWRITE <= bus.write;
        bus.PWDATA <= bus.wdata;
        bus.PSEL   <= NUM_SLV'(1) << dec_idx;
      end else begin
        state    <= DECERR;
        bus.PSEL <= '0;
      end
    end else begin
      case (state)
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (complete) begin
            state       <= IDLE;
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
          end
        end
        DECERR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_multi.sv
// tb/tb_apb_master_multi.sv - directed self-checking bench for apb_master_multi
`timescale 1ns/1ps
module tb_apb_master_multi;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  apb_master_multi_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) bus ();

  apb_master_multi #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) dut (
    .PCLK    (pclk),
    .PRESETn (presetn),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #2;
  endtask

  task automatic req(input logic t, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.transfer = t;
    bus.write    = w;
    bus.addr     = a;
    bus.wdata    = d;
  endtask

  task automatic test_reset();
    tick();
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err} !== 7'b0000_000) begin n_bad++; $display("FAIL reset_ctrl got %b want 0000000", {bus.PSEL, bus.PENABLE, bus.ready, bus.err}); end
    n_cmp++; if ({bus.PADDR, bus.PWDATA, bus.PWRITE, bus.rdata} !== 97'd0) begin n_bad++; $display("FAIL reset_data got paddr=%h pwdata=%h pwrite=%b rdata=%h want all 0", bus.PADDR, bus.PWDATA, bus.PWRITE, bus.rdata); end
    presetn = 1'b1;
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready} !== 6'b0000_00) begin n_bad++; $display("FAIL reset_idle got %b want 000000", {bus.PSEL, bus.PENABLE, bus.ready}); end
  endtask

  task automatic test_write();
    bus.PREADY = 4'b0001; bus.PSLVERR = 4'b0000;
    req(1'b1, 1'b1, 32'h1000_0000, 32'h0000_000A);
    #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL wr_idle_ready got %b want 0", bus.ready); end
    tick();
    req(1'b0, 1'b0, 32'h1000_3000, 32'hFFFF_FFFF);
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err} !== 7'b0001_000) begin n_bad++; $display("FAIL wr_setup got %b want 0001000", {bus.PSEL, bus.PENABLE, bus.ready, bus.err}); end
    n_cmp++; if ({bus.PADDR, bus.PWRITE, bus.PWDATA} !== {32'h1000_0000, 1'b1, 32'h0000_000A}) begin n_bad++; $display("FAIL wr_latch got %h %b %h want 10000000 1 0000000a", bus.PADDR, bus.PWRITE, bus.PWDATA); end
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err} !== 7'b0001_110) begin n_bad++; $display("FAIL wr_access got %b want 0001110", {bus.PSEL, bus.PENABLE, bus.ready, bus.err}); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata got %h want 0", bus.rdata); end
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.PADDR} !== {6'b0000_00, 32'h1000_0000}) begin n_bad++; $display("FAIL wr_idle_hold got psel=%b pen=%b rdy=%b paddr=%h want 0 0 0 10000000", bus.PSEL, bus.PENABLE, bus.ready, bus.PADDR); end
  endtask

  task automatic test_read_wait();
    bus.PREADY = 4'b0000;
    req(1'b1, 1'b0, 32'h1000_1004, 32'h0);
    tick();
    bus.transfer = 1'b0;
    bus.PREADY   = 4'b0001;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.PADDR} !== {6'b0010_00, 32'h1000_1004}) begin n_bad++; $display("FAIL rd_setup got psel=%b pen=%b rdy=%b paddr=%h want 0010 0 0 10001004", bus.PSEL, bus.PENABLE, bus.ready, bus.PADDR); end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err, bus.rdata} !== {7'b0010_100, 32'h0}) begin n_bad++; $display("FAIL rd_wait%0d got %b rdata=%h want 0010100 rdata=0", i, {bus.PSEL, bus.PENABLE, bus.ready, bus.err}, bus.rdata); end
    end
    tick();
    bus.PREADY = 4'b0010;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err, bus.rdata} !== {7'b0010_110, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL rd_done got %b rdata=%h want 0010110 rdata=deadbeef", {bus.PSEL, bus.PENABLE, bus.ready, bus.err}, bus.rdata); end
    tick();
    bus.PREADY = 4'b0000;
    #1;
    n_cmp++; if ({bus.PSEL, bus.ready, bus.rdata} !== {5'b0000_0, 32'h0}) begin n_bad++; $display("FAIL rd_after got psel=%b rdy=%b rdata=%h want 0 0 0", bus.PSEL, bus.ready, bus.rdata); end
  endtask

  task automatic test_decerr();
    logic [31:0] miss [2];
    miss[0] = 32'h2000_0000;
    miss[1] = 32'h1000_4000;
    bus.PREADY = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      req(1'b1, 1'b0, miss[i], 32'h0);
      tick();
      bus.transfer = 1'b0;
      #1;
      n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err, bus.rdata} !== {7'b0000_011, 32'h0}) begin n_bad++; $display("FAIL decerr%0d got %b rdata=%h want 0000011 rdata=0", i, {bus.PSEL, bus.PENABLE, bus.ready, bus.err}, bus.rdata); end
      tick();
      #1;
      n_cmp++; if ({bus.PSEL, bus.ready, bus.err} !== 6'b0000_00) begin n_bad++; $display("FAIL decerr%0d_idle got %b want 000000", i, {bus.PSEL, bus.ready, bus.err}); end
    end
    bus.PREADY = 4'b0000;
  endtask

  task automatic test_back_to_back();
    bus.PREADY = 4'b0101;
    req(1'b1, 1'b1, 32'h1000_0000, 32'h0000_00B0);
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 5'b0001_0) begin n_bad++; $display("FAIL b2b_setup1 got %b want 00010", {bus.PSEL, bus.PENABLE}); end
    tick();
    req(1'b1, 1'b0, 32'h1000_2000, 32'h0);
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err} !== 7'b0001_110) begin n_bad++; $display("FAIL b2b_done1 got %b want 0001110", {bus.PSEL, bus.PENABLE, bus.ready, bus.err}); end
    tick();
    bus.transfer = 1'b0;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.PWRITE, bus.PADDR} !== {7'b0100_000, 32'h1000_2000}) begin n_bad++; $display("FAIL b2b_setup2 got psel=%b pen=%b rdy=%b pw=%b paddr=%h want 0100 0 0 0 10002000", bus.PSEL, bus.PENABLE, bus.ready, bus.PWRITE, bus.PADDR); end
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.ready, bus.err, bus.rdata} !== {6'b0100_10, 32'h2222_0002}) begin n_bad++; $display("FAIL b2b_done2 got %b rdata=%h want 010010 rdata=22220002", {bus.PSEL, bus.ready, bus.err}, bus.rdata); end
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 5'b0000_0) begin n_bad++; $display("FAIL b2b_idle got %b want 00000", {bus.PSEL, bus.PENABLE}); end
    bus.PREADY = 4'b0000;
  endtask

  task automatic test_slverr();
    bus.PREADY  = 4'b1001;
    bus.PSLVERR = 4'b1000;
    req(1'b1, 1'b1, 32'h1000_3000, 32'h0000_0033);
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 5'b1000_0) begin n_bad++; $display("FAIL slverr_setup got %b want 10000", {bus.PSEL, bus.PENABLE}); end
    tick();
    req(1'b1, 1'b0, 32'h1000_0008, 32'h0);
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err} !== 7'b1000_111) begin n_bad++; $display("FAIL slverr_done got %b want 1000111", {bus.PSEL, bus.PENABLE, bus.ready, bus.err}); end
    tick();
    bus.transfer = 1'b0;
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.ready, bus.err, bus.rdata} !== {6'b0001_10, 32'h0000_5A5A}) begin n_bad++; $display("FAIL slverr_next got %b rdata=%h want 000110 rdata=00005a5a", {bus.PSEL, bus.ready, bus.err}, bus.rdata); end
    tick();
    bus.PREADY  = 4'b0000;
    bus.PSLVERR = 4'b0000;
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    bus.PREADY = 4'b0000;
    req(1'b1, 1'b0, 32'h1000_2000, 32'h0);
    tick();
    bus.transfer = 1'b0;
`ifdef APB_TIMEOUT_EN
    for (int i = 1; i <= 15; i++) begin
      tick();
      #1;
      if (bus.ready === 1'b1) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL tmo_early got %0d ready cycles want 0", early); end
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err, bus.rdata} !== {7'b0100_111, 32'h0}) begin n_bad++; $display("FAIL tmo_fire got %b rdata=%h want 0100111 rdata=0", {bus.PSEL, bus.PENABLE, bus.ready, bus.err}, bus.rdata); end
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready} !== 6'b0000_00) begin n_bad++; $display("FAIL tmo_drop got %b want 000000", {bus.PSEL, bus.PENABLE, bus.ready}); end
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      #1;
      if (bus.ready === 1'b1) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL wait_nontmo got %0d ready cycles want 0", early); end
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 5'b0100_1) begin n_bad++; $display("FAIL wait_hold got %b want 01001", {bus.PSEL, bus.PENABLE}); end
    bus.PREADY = 4'b0100;
    #1;
    n_cmp++; if ({bus.ready, bus.err, bus.rdata} !== {2'b10, 32'h2222_0002}) begin n_bad++; $display("FAIL wait_done got rdy=%b err=%b rdata=%h want 1 0 22220002", bus.ready, bus.err, bus.rdata); end
    tick();
    bus.PREADY = 4'b0000;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 5'b0000_0) begin n_bad++; $display("FAIL wait_idle got %b want 00000", {bus.PSEL, bus.PENABLE}); end
`endif
  endtask

  task automatic test_reset_mid();
    bus.PREADY = 4'b0000;
    req(1'b1, 1'b1, 32'h1000_1000, 32'h0000_00CC);
    tick();
    bus.transfer = 1'b0;
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 5'b0010_1) begin n_bad++; $display("FAIL rstmid_access got %b want 00101", {bus.PSEL, bus.PENABLE}); end
    presetn = 1'b0;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready, bus.err, bus.PWRITE, bus.PADDR, bus.PWDATA} !== 72'd0) begin n_bad++; $display("FAIL rstmid_async got psel=%b pen=%b rdy=%b err=%b pw=%b paddr=%h pwdata=%h want all 0", bus.PSEL, bus.PENABLE, bus.ready, bus.err, bus.PWRITE, bus.PADDR, bus.PWDATA); end
    bus.PREADY = 4'b0010;
    #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_noready got %b want 0", bus.ready); end
    tick();
    presetn = 1'b1;
    tick();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.ready} !== 6'b0000_00) begin n_bad++; $display("FAIL rstmid_lost got %b want 000000", {bus.PSEL, bus.PENABLE, bus.ready}); end
    bus.PREADY = 4'b0001;
    req(1'b1, 1'b0, 32'h1000_0000, 32'h0);
    tick();
    bus.transfer = 1'b0;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 5'b0001_0) begin n_bad++; $display("FAIL rstmid_restart got %b want 00010", {bus.PSEL, bus.PENABLE}); end
    tick();
    #1;
    n_cmp++; if ({bus.ready, bus.err, bus.rdata} !== {2'b10, 32'h0000_5A5A}) begin n_bad++; $display("FAIL rstmid_read got rdy=%b err=%b rdata=%h want 1 0 00005a5a", bus.ready, bus.err, bus.rdata); end
    tick();
  endtask

  initial begin
    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.PREADY   = '0;
    bus.PSLVERR  = '0;
    bus.PRDATA   = {32'h3333_3333, 32'h2222_0002, 32'hDEAD_BEEF, 32'h0000_5A5A};
    test_reset();
    test_write();
    test_read_wait();
    test_decerr();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired before bench completion");
    $fatal(1);
  end

endmodule
